regfile_sb: RTL

Parametrised multi-port register file with integrated scoreboard for the pipelined core. It provides NREAD combinational read ports with same-cycle write-through bypass and NWRITE synchronous write ports with fixed priority. A busy bit per register is set when an instruction is issued and cleared on writeback, so decode can stall on RAW hazards without a separate hazard unit. Register 0 is hardwired to zero.

---
 rtl/regfile_pkg.sv | 13 +
 rtl/regfile_scoreboard.sv | 73 +++++++
 rtl/regfile_sb.sv | 78 +++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the register file and its scoreboard.
// Default data/register-count parameters, address-width helper, zero index.
package regfile_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;
    localparam int ZERO_REG  = 0;

    function automatic int aw_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: issue sets, writeback clears, flush clears all.
// Ports: clk_i/rst_i, wr_en_i/wr_addr_i, iss_en_i/iss_rd_i, flush_i,
//        rd_addr_i -> rd_ready_o, busy_cnt_o (registered popcount).
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter  int NREGS  = NREGS_DEF,
    parameter  int NREAD  = 2,
    parameter  int NWRITE = 2,
    localparam int AW     = aw_of(NREGS),
    localparam int CW     = AW + 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NWRITE-1:0]    wr_en_i,
    input  logic [NWRITE*AW-1:0] wr_addr_i,
    input  logic                 iss_en_i,
    input  logic [AW-1:0]        iss_rd_i,
    input  logic                 flush_i,
    input  logic [NREAD*AW-1:0]  rd_addr_i,
    output logic [NREAD-1:0]     rd_ready_o,
    output logic [CW-1:0]        busy_cnt_o
);

    logic [NREGS-1:0] busy_q, busy_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [NREAD-1:0] hit;

    // Clear on writeback first, then issue (newer producer) wins,
    // then flush overrides everything.
    always_comb begin
        busy_d = busy_q;
        for (int j = 0; j < NWRITE; j++) begin
            if (wr_en_i[j]) busy_d[wr_addr_i[j*AW +: AW]] = 1'b0;
        end
        if (iss_en_i && iss_rd_i != AW'(ZERO_REG)) busy_d[iss_rd_i] = 1'b1;
        if (flush_i) busy_d = '0;
        busy_d[ZERO_REG] = 1'b0;
        cnt_d = '0;
        for (int r = 0; r < NREGS; r++) begin
            cnt_d = cnt_d + CW'(busy_d[r]);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    // A completing write to the operand makes it ready via bypass.
    always_comb begin
        hit        = '0;
        rd_ready_o = '0;
        for (int i = 0; i < NREAD; i++) begin
            for (int j = 0; j < NWRITE; j++) begin
                if (wr_en_i[j] && wr_addr_i[j*AW +: AW] == rd_addr_i[i*AW +: AW])
                    hit[i] = 1'b1;
            end
            rd_ready_o[i] = rst_i
                || rd_addr_i[i*AW +: AW] == AW'(ZERO_REG)
                || !busy_q[rd_addr_i[i*AW +: AW]]
                || hit[i];
        end
    end

    assign busy_cnt_o = cnt_q;

endmodule

// File: rtl/regfile_sb.sv
// Multi-port register file with write-through bypass and busy scoreboard.
// Ports: clk/rst, rd_addr -> rd_data/rd_ready, wr_en/wr_addr/wr_data,
//        iss_en/iss_rd (mark busy), flush (clear busy), busy_cnt.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter  int XLEN   = XLEN_DEF,
    parameter  int NREGS  = NREGS_DEF,
    parameter  int NREAD  = 2,
    parameter  int NWRITE = 2,
    localparam int AW     = aw_of(NREGS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREAD*AW-1:0]    rd_addr,
    output logic [NREAD*XLEN-1:0]  rd_data,
    output logic [NREAD-1:0]       rd_ready,
    input  logic [NWRITE-1:0]      wr_en,
    input  logic [NWRITE*AW-1:0]   wr_addr,
    input  logic [NWRITE*XLEN-1:0] wr_data,
    input  logic                   iss_en,
    input  logic [AW-1:0]          iss_rd,
    input  logic                   flush,
    output logic [AW:0]            busy_cnt
);

    logic [XLEN-1:0]   mem_q [NREGS];
    logic [XLEN-1:0]   mem_d [NREGS];
    logic [NWRITE-1:0] we;

    // Writes (and therefore bypass) are suppressed while in reset.
    assign we = wr_en & {NWRITE{~rst}};

    // Ascending port loop: the highest-index port lands last and wins.
    always_comb begin
        mem_d = mem_q;
        for (int j = 0; j < NWRITE; j++) begin
            if (we[j] && wr_addr[j*AW +: AW] != AW'(ZERO_REG))
                mem_d[wr_addr[j*AW +: AW]] = wr_data[j*XLEN +: XLEN];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) mem_q <= '{default: '0};
        else     mem_q <= mem_d;
    end

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NREAD; i++) begin
            if (rd_addr[i*AW +: AW] != AW'(ZERO_REG)) begin
                rd_data[i*XLEN +: XLEN] = mem_q[rd_addr[i*AW +: AW]];
                for (int j = 0; j < NWRITE; j++) begin
                    if (we[j] && wr_addr[j*AW +: AW] == rd_addr[i*AW +: AW])
                        rd_data[i*XLEN +: XLEN] = wr_data[j*XLEN +: XLEN];
                end
            end
        end
    end

    regfile_scoreboard #(
        .NREGS  (NREGS),
        .NREAD  (NREAD),
        .NWRITE (NWRITE)
    ) u_sb (
        .clk_i      (clk),
        .rst_i      (rst),
        .wr_en_i    (we),
        .wr_addr_i  (wr_addr),
        .iss_en_i   (iss_en & ~rst),
        .iss_rd_i   (iss_rd),
        .flush_i    (flush),
        .rd_addr_i  (rd_addr),
        .rd_ready_o (rd_ready),
        .busy_cnt_o (busy_cnt)
    );

endmodule
